instruction_fetch: RTL and testbench

- Front-end stage that sits directly upstream of the instruction decoder.
- Owns the PC, fetches 16-bit instructions over a request/grant/response instruction-memory port, and holds the current instruction in an IF/ID output register.
- Splits the instruction into the fields the decoder consumes: opcode, immediate, offset, nzimm.
- Handles pipeline stall (one-entry skid buffer) and branch redirect (flush plus discard of in-flight responses).

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_skid_buf.sv | 55 +++++
 rtl/instruction_fetch.sv | 180 ++++++++++++++++++
 tb/tb_instruction_fetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared front-end definitions: fetch FSM states, instruction field
// positions and default bus widths. The decoder uses the same field widths.
package riscv_pkg;

  localparam int ADDR_W_DEFAULT  = 16;
  localparam int INSTR_W_DEFAULT = 16;

  // Instruction field positions
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int IMM_W   = 7;
  localparam int OFF_W   = 9;
  localparam int NZIMM_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DRAIN = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched instruction and its address.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   i_clear          drop the held entry (redirect); wins over load/unload
//   i_load           capture i_pc/i_instr, buffer becomes full
//   i_unload         entry moved downstream, buffer becomes empty
//   i_pc, i_instr    entry to capture
//   o_full           buffer holds an entry
//   o_pc, o_instr    held entry
module fetch_skid_buf
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int INSTR_W = INSTR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic               i_unload,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_full,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr
);

  logic               r_full;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;

  // Buffer occupancy and payload
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_clear) begin
      r_full  <= 1'b0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_unload) begin
      r_full  <= 1'b0;
    end else begin
      r_full  <= r_full;
    end
  end

  assign o_full  = r_full;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches 16-bit instructions over a
// req/gnt/rvalid memory port (one outstanding transaction) and holds the
// current instruction in the IF/ID register, with a one-entry skid buffer
// for stalls and a redirect path that flushes and drains in-flight data.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   imem_req/addr, imem_gnt         fetch request, byte address (= pc), grant
//   imem_rvalid, imem_rdata         fetch response
//   stall                           downstream holds the IF/ID register
//   branch_taken, branch_target     redirect (bit 0 of target ignored)
//   if_valid, if_pc, if_instr       IF/ID register
//   opcode, immediate, offset, nzimm  decoder fields sliced from if_instr
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter int                INSTR_W  = INSTR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic [ADDR_W-1:0]        branch_target,
  output logic                     if_valid,
  output logic [ADDR_W-1:0]        if_pc,
  output logic [INSTR_W-1:0]       if_instr,
  output logic [OPC_HI-OPC_LO:0]   opcode,
  output logic [IMM_W-1:0]         immediate,
  output logic [OFF_W-1:0]         offset,
  output logic [NZIMM_W-1:0]       nzimm
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_req_pc;
  logic               r_imem_req;
  logic               r_if_valid;
  logic [ADDR_W-1:0]  r_if_pc;
  logic [INSTR_W-1:0] r_if_instr;

  logic               w_consume;
  logic               w_slot_open;
  logic               w_resp_take;
  logic               w_skid_load;
  logic               w_skid_unload;
  logic               w_skid_full_nxt;
  logic               w_skid_full;
  logic [ADDR_W-1:0]  w_skid_pc;
  logic [INSTR_W-1:0] w_skid_instr;

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (branch_taken),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_pc     (r_req_pc),
    .i_instr  (imem_rdata),
    .o_full   (w_skid_full),
    .o_pc     (w_skid_pc),
    .o_instr  (w_skid_instr)
  );

  // Slot/skid handshakes and next FSM state
  always_comb begin
    w_consume   = r_if_valid & ~stall;
    w_slot_open = ~r_if_valid | w_consume;
    // A response is only kept when it is not overtaken by a redirect
    w_resp_take   = (r_state == ST_WAIT) & imem_rvalid & ~branch_taken;
    w_skid_load   = w_resp_take & ~w_slot_open;
    w_skid_unload = ~branch_taken & w_consume & w_skid_full;
    if (branch_taken) begin
      w_skid_full_nxt = 1'b0;
    end else if (w_skid_load) begin
      w_skid_full_nxt = 1'b1;
    end else if (w_skid_unload) begin
      w_skid_full_nxt = 1'b0;
    end else begin
      w_skid_full_nxt = w_skid_full;
    end

    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (branch_taken || !w_skid_full_nxt) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (imem_gnt) begin
          w_state_nxt = branch_taken ? ST_DRAIN : ST_WAIT;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (branch_taken) begin
          w_state_nxt = imem_rvalid ? ST_REQ : ST_DRAIN;
        end else if (imem_rvalid) begin
          w_state_nxt = w_skid_full_nxt ? ST_IDLE : ST_REQ;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        // The stale response ends the drain even if another redirect
        // arrives with it; nothing else is outstanding to wait for.
        if (imem_rvalid) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM, PC, granted-address capture and IF/ID register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_imem_req <= 1'b0;
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_imem_req <= (w_state_nxt == ST_REQ);
      if (branch_taken) begin
        r_pc       <= branch_target & ~ADDR_W'(1);
        r_if_valid <= 1'b0;
      end else begin
        if ((r_state == ST_REQ) && imem_gnt) begin
          r_pc     <= r_pc + ADDR_W'(2);
          r_req_pc <= r_pc;
        end
        if (w_resp_take && w_slot_open) begin
          r_if_valid <= 1'b1;
          r_if_pc    <= r_req_pc;
          r_if_instr <= imem_rdata;
        end else if (w_skid_unload) begin
          r_if_valid <= 1'b1;
          r_if_pc    <= w_skid_pc;
          r_if_instr <= w_skid_instr;
        end else if (w_consume) begin
          r_if_valid <= 1'b0;
        end else begin
          r_if_valid <= r_if_valid;
        end
      end
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;
  assign opcode    = r_if_instr[OPC_HI:OPC_LO];
  assign immediate = r_if_instr[IMM_W-1:0];
  assign offset    = r_if_instr[OFF_W-1:0];
  assign nzimm     = r_if_instr[NZIMM_W-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_gnt, imem_rvalid, stall, branch_taken;
  logic [15:0] imem_rdata, branch_target;
  logic        imem_req, if_valid;
  logic [15:0] imem_addr, if_pc, if_instr;
  logic [3:0]  opcode;
  logic [6:0]  immediate;
  logic [8:0]  offset;
  logic [5:0]  nzimm;

  // second instance, RESET_PC = 16'hFFFE
  logic        imem_gnt_w, imem_rvalid_w, stall_w, branch_taken_w;
  logic [15:0] imem_rdata_w, branch_target_w;
  logic        imem_req_w, if_valid_w;
  logic [15:0] imem_addr_w, if_pc_w, if_instr_w;
  logic [3:0]  opcode_w;
  logic [6:0]  immediate_w;
  logic [8:0]  offset_w;
  logic [5:0]  nzimm_w;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .opcode(opcode),
    .immediate(immediate), .offset(offset), .nzimm(nzimm)
  );

  instruction_fetch #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_gnt(imem_gnt_w), .imem_rvalid(imem_rvalid_w), .imem_rdata(imem_rdata_w),
    .stall(stall_w), .branch_taken(branch_taken_w), .branch_target(branch_target_w),
    .if_valid(if_valid_w), .if_pc(if_pc_w), .if_instr(if_instr_w), .opcode(opcode_w),
    .immediate(immediate_w), .offset(offset_w), .nzimm(nzimm_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sb_pops = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } sb_t;
  sb_t sbq[$];

  // memory model state
  logic        pend = 1'b0, pend_discard = 1'b0;
  int          cnt = 0;
  int          mem_lat = 1;
  logic [15:0] pend_addr = 16'h0000;
  logic        pend_w = 1'b0;
  logic [15:0] pend_addr_w = 16'h0000;

  typedef struct {
    logic        stall_in;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
    logic        exp_req_w;
    logic [15:0] exp_addr_w;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h3A05;
    return a ^ 16'hC6B0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // one clock: present memory response, scoreboard, advance, update memory model
  task automatic step();
    logic rv, rv_w, fire, fire_w;
    logic [15:0] faddr, faddr_w;
    sb_t exp_e;
    rv = pend && (cnt == 1) && rst_n;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend_addr) : 16'h0000;
    rv_w = pend_w && rst_n;
    imem_rvalid_w = rv_w;
    imem_rdata_w  = rv_w ? mem_word(pend_addr_w) : 16'h0000;
    fire    = imem_req && imem_gnt;
    faddr   = imem_addr;
    fire_w  = imem_req_w && imem_gnt_w;
    faddr_w = imem_addr_w;
    if (rst_n) begin
      if (imem_req && pend) chk("one_outstanding", 32'(pend), 32'd0);
      if (if_valid && !stall && !branch_taken) begin
        if (sbq.size() == 0) begin
          chk("sb_extra", 32'(if_pc), 32'hFFFFFFFF);
        end else begin
          exp_e = sbq.pop_front();
          sb_pops++;
          chk("sb_pc_instr", {if_pc, if_instr}, {exp_e.pc, exp_e.instr});
          chk("sb_fields", {opcode, immediate, offset, nzimm},
              {exp_e.instr[15:12], exp_e.instr[6:0], exp_e.instr[8:0], exp_e.instr[5:0]});
        end
      end
      if (rv && !pend_discard && !branch_taken) sbq.push_back({pend_addr, mem_word(pend_addr)});
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pend = 1'b0; pend_w = 1'b0; sbq.delete();
    end else begin
      if (branch_taken) begin
        sbq.delete();
        if (pend) pend_discard = 1'b1;
      end
      if (rv) pend = 1'b0;
      else if (pend) cnt--;
      if (fire) begin
        pend = 1'b1; cnt = mem_lat; pend_addr = faddr; pend_discard = branch_taken;
      end
      if (rv_w) pend_w = 1'b0;
      if (fire_w) begin pend_w = 1'b1; pend_addr_w = faddr_w; end
    end
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20; k++) begin
      if (imem_req) break;
      step();
    end
    chk("wait_req", 32'(imem_req), 32'd1);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFFFE};
    tbl[1] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFE};
    tbl[2] = '{1'b0, 1'b0, 16'h0002, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[3] = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'h3A05, 1'b1, 16'h0000};
    tbl[4] = '{1'b0, 1'b0, 16'h0004, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0002};
    tbl[5] = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'hC6B2, 1'b1, 16'h0002};
    tbl[6] = '{1'b0, 1'b0, 16'h0006, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0004};
    tbl[7] = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'h0004, 16'hC6B4, 1'b1, 16'h0004};
    tbl[8] = '{1'b0, 1'b0, 16'h0008, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0006};
    tbl[9] = '{1'b0, 1'b1, 16'h0008, 1'b1, 16'h0006, 16'hC6B6, 1'b1, 16'h0006};

    rst_n = 1'b0; imem_gnt = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 16'h0000; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
    imem_gnt_w = 1'b1; stall_w = 1'b0; branch_taken_w = 1'b0;
    branch_target_w = 16'h0000; imem_rvalid_w = 1'b0; imem_rdata_w = 16'h0000;
    step();
    step();
    chk("reset_fields", {if_instr, opcode, immediate, offset, nzimm, if_pc}, 32'h0);
    rst_n = 1'b1;

    // table: reset state then back-to-back fetch with 1-cycle memory
    for (int i = 0; i < 10; i++) begin
      stall = tbl[i].stall_in;
      if (i > 0) step();
      chk($sformatf("tbl%0d_req_addr", i), {imem_req, imem_addr, if_valid},
          {tbl[i].exp_req, tbl[i].exp_addr, tbl[i].exp_valid});
      if (tbl[i].exp_valid)
        chk($sformatf("tbl%0d_slot", i), {if_pc, if_instr}, {tbl[i].exp_pc, tbl[i].exp_instr});
      chk($sformatf("tbl%0d_wrap", i), {imem_req_w, imem_addr_w},
          {tbl[i].exp_req_w, tbl[i].exp_addr_w});
      if (i == 3)
        chk("tbl3_fields", {opcode, immediate, offset, nzimm}, {4'h3, 7'h05, 9'h005, 6'h05});
    end

    // stall with skid fill
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("stall%0d_hold", k), {if_valid, if_pc, imem_req}, {1'b1, 16'h0006, 1'b0});
      chk($sformatf("stall%0d_instr", k), if_instr, 16'hC6B6);
    end
    stall = 1'b0;
    step();
    chk("skid_out", {if_valid, if_pc, if_instr}, {1'b1, 16'h0008, 16'hC6B8});
    chk("skid_req", {imem_req, imem_addr}, {1'b1, 16'h000A});
    step();
    chk("skid_empty", if_valid, 1'b0);

    // redirect during WAIT, late response drained
    wait_req();
    mem_lat = 2;
    step();
    branch_taken = 1'b1; branch_target = 16'h0041;
    step();
    branch_taken = 1'b0;
    chk("drain_enter", {imem_req, imem_addr, if_valid}, {1'b0, 16'h0040, 1'b0});
    step();
    chk("drain_discard", {imem_req, imem_addr, if_valid}, {1'b1, 16'h0040, 1'b0});
    mem_lat = 1;
    step();
    chk("drain_grant", if_valid, 1'b0);
    step();
    chk("target_arrive", {if_valid, if_pc, if_instr}, {1'b1, 16'h0040, 16'hC6F0});

    // redirect in the same cycle as rvalid
    step();
    branch_taken = 1'b1; branch_target = 16'h0100;
    step();
    branch_taken = 1'b0;
    chk("br_rv_state", {imem_req, imem_addr, if_valid}, {1'b1, 16'h0100, 1'b0});
    chk("br_rv_nodata", 32'(if_instr == 16'hC6F2), 32'd0);
    step();
    chk("br_rv_grant", if_valid, 1'b0);
    step();
    chk("br_rv_target", {if_valid, if_pc, if_instr}, {1'b1, 16'h0100, 16'hC7B0});

    // redirect in REQ with grant -> drain
    branch_taken = 1'b1; branch_target = 16'h0200;
    step();
    branch_taken = 1'b0;
    chk("req_gnt_br", {imem_req, imem_addr, if_valid}, {1'b0, 16'h0200, 1'b0});
    step();
    chk("req_gnt_drain", {imem_req, imem_addr, if_valid}, {1'b1, 16'h0200, 1'b0});

    // redirect in REQ without grant
    imem_gnt = 1'b0; branch_taken = 1'b1; branch_target = 16'h0300;
    step();
    branch_taken = 1'b0; imem_gnt = 1'b1;
    chk("req_nogn_br", {imem_req, imem_addr}, {1'b1, 16'h0300});

    // reset during WAIT with a held instruction
    stall = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (if_valid && imem_req) break;
      step();
    end
    chk("pre_rst_ready", {if_valid, imem_req}, {1'b1, 1'b1});
    step();
    chk("pre_rst_wait", {if_valid, imem_req}, {1'b1, 1'b0});
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; stall = 1'b0;
    chk("mid_rst", {if_valid, imem_req, imem_addr}, {1'b0, 1'b0, 16'h0000});
    step();
    chk("post_rst_req", {if_valid, imem_req, imem_addr}, {1'b0, 1'b1, 16'h0000});
    step();
    step();
    step();
    chk("sb_pops", 32'(sb_pops >= 8), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
